// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
// State enum, ALU control codes, data-processing command codes and op classes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: maps aluop and the cmd/S fields to ALU control and flag-write intents.
// Unsupported commands fall back to ADD with no flag writes.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic       aluop,
    input  logic [4:0] funct,
    output logic [1:0] alucontrol,
    output logic [1:0] flagw
);

    logic s_bit;

    assign s_bit = funct[0];

    // Only ADD/SUB produce meaningful carry/overflow, so CV tracks S just for those.
    always_comb begin
        alucontrol = ALU_ADD;
        flagw      = 2'b00;
        if (aluop) begin
            case (funct[4:1])
                CMD_ADD: begin
                    alucontrol = ALU_ADD;
                    flagw      = {s_bit, s_bit};
                end
                CMD_SUB: begin
                    alucontrol = ALU_SUB;
                    flagw      = {s_bit, s_bit};
                end
                CMD_AND: begin
                    alucontrol = ALU_AND;
                    flagw      = {s_bit, 1'b0};
                end
                CMD_ORR: begin
                    alucontrol = ALU_ORR;
                    flagw      = {s_bit, 1'b0};
                end
                default: begin
                    alucontrol = ALU_ADD;
                    flagw      = 2'b00;
                end
            endcase
        end
    end

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle control unit: Moore main FSM with ALU and PC decode.
// Write intents are unconditional here; the condition-logic stage gates them downstream.
//
//   state    | meaning
//   FETCH    | load IR, PC <= PC+4
//   DECODE   | read registers, compute PC+8
//   MEMADR   | compute load/store address
//   MEMRD    | read data memory
//   MEMWB    | write loaded data to register file
//   MEMWR    | write data memory
//   EXECUTER | ALU op with register operand
//   EXECUTEI | ALU op with immediate operand
//   ALUWB    | write ALU result to register file
//   BRANCH   | compute branch target, write PC
//   UNKNOWN  | undefined op: one idle cycle, no writes
module mc_main_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    output logic       irwrite,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [1:0] alucontrol,
    output logic [1:0] flagw,
    output logic       pcs,
    output logic       nextpc,
    output logic       regw,
    output logic       memw,
    output logic [1:0] immsrc,
    output logic [1:0] regsrc
);

    state_t     state_q;
    state_t     state_d;

    logic       aluop;
    logic       branch;
    logic       irwrite_raw;
    logic       nextpc_raw;
    logic       regw_raw;
    logic       memw_raw;
    logic       pcs_raw;
    logic [1:0] flagw_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        irwrite_raw = 1'b0;
        adrsrc      = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        resultsrc   = 2'b00;
        nextpc_raw  = 1'b0;
        regw_raw    = 1'b0;
        memw_raw    = 1'b0;
        branch      = 1'b0;
        aluop       = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrca     = 1'b1;
                alusrcb     = 2'b10;
                resultsrc   = 2'b10;
                irwrite_raw = 1'b1;
                nextpc_raw  = 1'b1;
            end
            S_DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
            end
            S_MEMADR: begin
                alusrcb = 2'b01;
            end
            S_MEMRD: begin
                adrsrc = 1'b1;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regw_raw  = 1'b1;
            end
            S_MEMWR: begin
                adrsrc   = 1'b1;
                memw_raw = 1'b1;
            end
            S_EXECUTER: begin
                aluop = 1'b1;
            end
            S_EXECUTEI: begin
                alusrcb = 2'b01;
                aluop   = 1'b1;
            end
            S_ALUWB: begin
                regw_raw = 1'b1;
            end
            S_BRANCH: begin
                alusrcb   = 2'b01;
                resultsrc = 2'b10;
                branch    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    mc_alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct[4:0]),
        .alucontrol (alucontrol),
        .flagw      (flagw_raw)
    );

    assign pcs_raw = branch | (regw_raw & (rd == PC_REG));

    // Reset must squash every write intent even before the state register has settled.
    assign irwrite = irwrite_raw & ~reset;
    assign nextpc  = nextpc_raw & ~reset;
    assign regw    = regw_raw & ~reset;
    assign memw    = memw_raw & ~reset;
    assign pcs     = pcs_raw & ~reset;
    assign flagw   = reset ? 2'b00 : flagw_raw;

    assign immsrc = op;
    assign regsrc = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_mc_main_controller.sv
// Self-checking bench for mc_main_controller: directed table, reset/undefined sequences,
// and random instruction streams checked against an instruction-step reference model.
module tb_mc_main_controller;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic [1:0] alucontrol;
        logic [1:0] flagw;
        logic       pcs;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
    } ctl_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        int         ncyc;
        logic [1:0] alucontrol;
        logic [1:0] flagw;
        logic       last_pcs;
        logic       last_regw;
        logic       last_memw;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] alucontrol;
    logic [1:0] flagw;
    logic       pcs;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic [1:0] immsrc;
    logic [1:0] regsrc;

    int n_vec;
    int n_err;

    mc_main_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .rd         (rd),
        .irwrite    (irwrite),
        .adrsrc     (adrsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .alucontrol (alucontrol),
        .flagw      (flagw),
        .pcs        (pcs),
        .nextpc     (nextpc),
        .regw       (regw),
        .memw       (memw),
        .immsrc     (immsrc),
        .regsrc     (regsrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic ctl_t dut_vec();
        ctl_t v;
        v.irwrite    = irwrite;
        v.adrsrc     = adrsrc;
        v.alusrca    = alusrca;
        v.alusrcb    = alusrcb;
        v.resultsrc  = resultsrc;
        v.alucontrol = alucontrol;
        v.flagw      = flagw;
        v.pcs        = pcs;
        v.nextpc     = nextpc;
        v.regw       = regw;
        v.memw       = memw;
        v.immsrc     = immsrc;
        v.regsrc     = regsrc;
        return v;
    endfunction

    // Cycles an instruction occupies, by class.
    function automatic int ref_len(input logic [1:0] o, input logic [5:0] f);
        if (o == 2'b01) return f[0] ? 5 : 4;
        if (o == 2'b00) return 4;
        return 3;
    endfunction

    // Expected controls for cycle 'step' of an instruction (step 0 = fetch).
    function automatic ctl_t ref_vec(input logic [1:0] o, input logic [5:0] f,
                                     input logic [3:0] r, input int step);
        ctl_t v;
        logic known;
        logic arith;
        v = '0;
        known = 1'b1;
        arith = 1'b0;
        v.immsrc = o;
        v.regsrc = {o == 2'b01, o == 2'b10};
        if (step <= 1) begin
            v.alusrca   = 1'b1;
            v.alusrcb   = 2'b10;
            v.resultsrc = 2'b10;
            v.irwrite   = (step == 0);
            v.nextpc    = (step == 0);
        end else if (o == 2'b00) begin
            if (step == 2) begin
                v.alusrcb = f[5] ? 2'b01 : 2'b00;
                case (f[4:1])
                    4'b0100: begin v.alucontrol = 2'b00; arith = 1'b1; end
                    4'b0010: begin v.alucontrol = 2'b01; arith = 1'b1; end
                    4'b0000: v.alucontrol = 2'b10;
                    4'b1100: v.alucontrol = 2'b11;
                    default: known = 1'b0;
                endcase
                v.flagw = known ? {f[0], f[0] & arith} : 2'b00;
            end else begin
                v.regw = 1'b1;
                v.pcs  = (r == 4'd15);
            end
        end else if (o == 2'b01) begin
            if (step == 2) begin
                v.alusrcb = 2'b01;
            end else if (step == 3) begin
                v.adrsrc = 1'b1;
                v.memw   = ~f[0];
            end else begin
                v.resultsrc = 2'b01;
                v.regw      = 1'b1;
                v.pcs       = (r == 4'd15);
            end
        end else if (o == 2'b10) begin
            v.alusrcb   = 2'b01;
            v.resultsrc = 2'b10;
            v.pcs       = 1'b1;
        end
        return v;
    endfunction

    function automatic ctl_t gate(input ctl_t v);
        ctl_t g;
        g = v;
        g.irwrite = 1'b0;
        g.nextpc  = 1'b0;
        g.regw    = 1'b0;
        g.memw    = 1'b0;
        g.pcs     = 1'b0;
        g.flagw   = 2'b00;
        return g;
    endfunction

    // Called at a negedge with the DUT in FETCH; returns at the next instruction's FETCH negedge.
    task automatic run_full(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                            input string tag);
        int n;
        op = o;
        funct = f;
        rd = r;
        n = ref_len(o, f);
        for (int s = 0; s < n; s++) begin
            #1;
            chk($sformatf("%s step%0d", tag, s), 32'(dut_vec()), 32'(ref_vec(o, f, r, s)));
            @(negedge clk);
        end
    endtask

    vec_t tbl[13];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        op = 2'b00;
        funct = 6'b0;
        rd = 4'd0;

        tbl[0]  = '{2'b00, 6'b001000, 4'd3,  4, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{2'b00, 6'b101000, 4'd3,  4, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{2'b00, 6'b000101, 4'd2,  4, 2'b01, 2'b11, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{2'b00, 6'b011001, 4'd1,  4, 2'b11, 2'b10, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{2'b00, 6'b000001, 4'd7,  4, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{2'b00, 6'b001001, 4'd0,  4, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{2'b00, 6'b011111, 4'd9,  4, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{2'b00, 6'b001000, 4'd15, 4, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{2'b01, 6'b011001, 4'd4,  5, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{2'b01, 6'b011000, 4'd4,  4, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{2'b01, 6'b011001, 4'd15, 5, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{2'b10, 6'b100000, 4'd0,  3, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{2'b11, 6'b111111, 4'd15, 3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

        // Power-on reset: two edges with reset high, check forced-off writes, then release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset hold", 32'(dut_vec()), 32'(gate(ref_vec(op, funct, rd, 0))));
        reset = 1'b0;

        foreach (tbl[i]) begin
            op = tbl[i].op;
            funct = tbl[i].funct;
            rd = tbl[i].rd;
            for (int s = 0; s < tbl[i].ncyc; s++) begin
                #1;
                if (s == 0) chk($sformatf("tbl%0d irwrite@fetch", i), 32'(irwrite), 32'd1);
                if (s == 2) begin
                    chk($sformatf("tbl%0d alucontrol", i), 32'(alucontrol), 32'(tbl[i].alucontrol));
                    chk($sformatf("tbl%0d flagw", i), 32'(flagw), 32'(tbl[i].flagw));
                end
                if (s == tbl[i].ncyc - 1) begin
                    chk($sformatf("tbl%0d last pcs", i), 32'(pcs), 32'(tbl[i].last_pcs));
                    chk($sformatf("tbl%0d last regw", i), 32'(regw), 32'(tbl[i].last_regw));
                    chk($sformatf("tbl%0d last memw", i), 32'(memw), 32'(tbl[i].last_memw));
                end
                @(negedge clk);
            end
            #1;
            chk($sformatf("tbl%0d back to fetch", i), 32'(irwrite), 32'd1);
        end

        // Reset asserted for two cycles while an LDR sits in MEMRD.
        op = 2'b01;
        funct = 6'b011001;
        rd = 4'd5;
        for (int s = 0; s < 4; s++) begin
            #1;
            chk($sformatf("ldr-abort step%0d", s), 32'(dut_vec()), 32'(ref_vec(op, funct, rd, s)));
            if (s < 3) @(negedge clk);
        end
        reset = 1'b1;
        #1;
        chk("reset in memrd", 32'(dut_vec()), 32'(gate(ref_vec(op, funct, rd, 3))));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("reset cycle%0d", c), 32'(dut_vec()), 32'(gate(ref_vec(op, funct, rd, 0))));
        end
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // The extra negedge above let the FSM leave FETCH; resync with a reset pulse.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_full(2'b01, 6'b011000, 4'd2, "str after reset");

        // Undefined op followed by a branch, full-vector checked.
        run_full(2'b11, 6'b010101, 4'd15, "undef");
        run_full(2'b10, 6'b000000, 4'd15, "branch");

        // Random instruction stream.
        for (int k = 0; k < 300; k++) begin
            logic [1:0] ro;
            logic [5:0] rf;
            logic [3:0] rr;
            ro = 2'($urandom_range(0, 3));
            rf = 6'($urandom);
            if ($urandom_range(0, 1) == 1) rf[4:1] = 4'($urandom_range(0, 3) * 2);
            if (rf[4:1] == 4'b0110) rf[4:1] = 4'b1100;
            rr = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            run_full(ro, rf, rr, $sformatf("rnd%0d op%b f%b rd%0d", k, ro, rf, rr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
